// File: rtl/simon_seq_engine.sv
// Simon/Genius round engine: per-player colour sequences, timed playback,
// element-by-element input checking and saturating per-player scores.
module simon_seq_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int COLOR_W     = 2,
  parameter int MAX_LEN     = 32,
  parameter int SCORE_W     = 8,
  parameter int SHOW_CYCLES = 4,
  localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int IW         = $clog2(MAX_LEN),
  localparam int LW         = IW + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           rnd_valid,
  input  logic [COLOR_W-1:0]             rnd_color,
  output logic                           rnd_ready,
  output logic                           out_valid,
  output logic [COLOR_W-1:0]             out_color,
  output logic                           ready,
  input  logic                           user_valid,
  input  logic [COLOR_W-1:0]             user_color,
  output logic                           correct,
  output logic                           fail,
  output logic [PW-1:0]                  cur_player,
  output logic [LW-1:0]                  seq_len,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           score_update,
  output logic                           game_over
);

  typedef enum logic [2:0] {IDLE, APPEND, SHOW, GAP, WAIT_IN, CHECK, NEXT, DONE} state_t;

  localparam int                 CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int                 SUM_W     = ((SCORE_W > LW) ? SCORE_W : LW) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state;
  logic [PW-1:0]      cur;
  logic [IW-1:0]      idx;
  logic [CNT_W-1:0]   show_cnt;
  logic [COLOR_W-1:0] user_q;
  logic               out_valid_q, ready_q, rnd_ready_q;
  logic [LW-1:0]      len_r   [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_r [NUM_PLAYERS];
  logic [COLOR_W-1:0] seq_mem [NUM_PLAYERS][MAX_LEN];

  logic [LW-1:0]      cur_len, idx_nxt;
  logic [IW-1:0]      idx_inc;
  logic [COLOR_W-1:0] cur_color, nxt_color, first_color;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic               idx_last, append_fire;

  assign cur_len     = len_r[cur];
  assign idx_inc     = idx + IW'(1);
  assign idx_nxt     = {1'b0, idx} + LW'(1);
  assign idx_last    = (idx_nxt == cur_len);
  assign cur_color   = seq_mem[cur][idx];
  assign nxt_color   = seq_mem[cur][idx_inc];
  // The colour being appended is not yet readable from storage on the append edge.
  assign first_color = (cur_len == '0) ? rnd_color : seq_mem[cur][IW'(0)];
  assign score_sum   = SUM_W'(score_r[cur]) + SUM_W'(cur_len);
  assign score_sat   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  assign append_fire = (state == APPEND) && rnd_valid && !abort;

  // abort blanks the handshake and display outputs in the same cycle it is seen.
  assign out_valid  = out_valid_q & ~abort;
  assign ready      = ready_q & ~abort;
  assign rnd_ready  = rnd_ready_q & ~abort;
  assign cur_player = cur;
  assign seq_len    = cur_len;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) scores[p*SCORE_W +: SCORE_W] = score_r[p];
  end

  // NOTE: sequence storage has no reset; per-player lengths gate every read of it.
  always_ff @(posedge clk) begin
    if (append_fire) seq_mem[cur][cur_len[IW-1:0]] <= rnd_color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      idx          <= '0;
      show_cnt     <= '0;
      user_q       <= '0;
      out_valid_q  <= 1'b0;
      out_color    <= '0;
      ready_q      <= 1'b0;
      rnd_ready_q  <= 1'b0;
      correct      <= 1'b0;
      fail         <= 1'b0;
      score_update <= 1'b0;
      game_over    <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        len_r[p]   <= '0;
        score_r[p] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update together.
      correct      <= 1'b0;
      fail         <= 1'b0;
      score_update <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        out_valid_q <= 1'b0;
        ready_q     <= 1'b0;
        rnd_ready_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              len_r[p]   <= '0;
              score_r[p] <= '0;
            end
            cur         <= '0;
            game_over   <= 1'b0;
            rnd_ready_q <= 1'b1;
            state       <= APPEND;
          end
          APPEND: if (rnd_valid) begin
            len_r[cur]  <= cur_len + LW'(1);
            idx         <= '0;
            show_cnt    <= '0;
            out_valid_q <= 1'b1;
            out_color   <= first_color;
            rnd_ready_q <= 1'b0;
            state       <= SHOW;
          end
          SHOW: begin
            if (show_cnt == CNT_W'(SHOW_CYCLES - 1)) begin
              out_valid_q <= 1'b0;
              state       <= GAP;
            end else begin
              show_cnt <= show_cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (idx_nxt < cur_len) begin
              idx         <= idx_inc;
              show_cnt    <= '0;
              out_valid_q <= 1'b1;
              out_color   <= nxt_color;
              state       <= SHOW;
            end else begin
              idx     <= '0;
              ready_q <= 1'b1;
              state   <= WAIT_IN;
            end
          end
          WAIT_IN: if (user_valid) begin
            user_q  <= user_color;
            ready_q <= 1'b0;
            state   <= CHECK;
          end
          CHECK: begin
            if (user_q != cur_color) begin
              fail       <= 1'b1;
              len_r[cur] <= '0;
              state      <= NEXT;
            end else if (!idx_last) begin
              idx     <= idx_inc;
              ready_q <= 1'b1;
              state   <= WAIT_IN;
            end else begin
              correct      <= 1'b1;
              score_update <= 1'b1;
              score_r[cur] <= score_sat;
              if (cur_len == LW'(MAX_LEN)) begin
                game_over <= 1'b1;
                state     <= DONE;
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            cur         <= (cur == PW'(NUM_PLAYERS - 1)) ? '0 : cur + PW'(1);
            rnd_ready_q <= 1'b1;
            state       <= APPEND;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: a per-player model predicts playback,
// verdict pulses and saturating scores for scripted and random rounds.
module tb_simon_seq_engine;

  localparam int NP = 3;
  localparam int CW = 2;
  localparam int ML = 4;
  localparam int SW = 4;
  localparam int SC = 4;
  localparam int PW = 2;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, rnd_valid = 1'b0, user_valid = 1'b0;
  logic [CW-1:0] rnd_color = '0, user_color = '0;
  logic rnd_ready, out_valid, ready, correct, fail, score_update, game_over;
  logic [CW-1:0] out_color;
  logic [PW-1:0] cur_player;
  logic [LW-1:0] seq_len;
  logic [NP*SW-1:0] scores;

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] m_seq [NP][ML];
  int m_len [NP];
  int m_score [NP];
  int m_cur;
  logic [CW-1:0] show_q [$];

  simon_seq_engine #(
    .NUM_PLAYERS(NP), .COLOR_W(CW), .MAX_LEN(ML), .SCORE_W(SW), .SHOW_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rnd_valid(rnd_valid), .rnd_color(rnd_color), .rnd_ready(rnd_ready),
    .out_valid(out_valid), .out_color(out_color), .ready(ready),
    .user_valid(user_valid), .user_color(user_color),
    .correct(correct), .fail(fail), .cur_player(cur_player), .seq_len(seq_len),
    .scores(scores), .score_update(score_update), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NP*SW-1:0] exp_scores();
    logic [NP*SW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*SW +: SW] = SW'(m_score[p]);
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_len[p]   = 0;
      m_score[p] = 0;
    end
    m_cur = 0;
    show_q.delete();
  endtask

  task automatic new_game();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_reset();
  endtask

  // One full turn: append c, watch playback, then press the sequence
  // (a wrong colour at index wrong_at, or all correct when wrong_at < 0).
  task automatic play_turn(input logic [CW-1:0] c, input int wrong_at, input bit poke_show);
    int p, n, budget;
    bit completed;
    logic [CW-1:0] exp_c, press;
    p = m_cur;
    budget = 0;
    while (rnd_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (rnd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL append_wait: rnd_ready=%b after %0d cycles, want 1", rnd_ready, budget);
    end
    vectors++;
    if (cur_player !== PW'(p) || seq_len !== LW'(m_len[p])) begin
      miscompares++;
      $display("FAIL turn_owner: player=%0d len=%0d, want player=%0d len=%0d",
               cur_player, seq_len, p, m_len[p]);
    end
    rnd_valid = 1'b1;
    rnd_color = c;
    m_seq[p][m_len[p]] = c;
    m_len[p]++;
    n = m_len[p];
    for (int i = 0; i < n; i++) show_q.push_back(m_seq[p][i]);
    @(negedge clk);
    rnd_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      exp_c = show_q.pop_front();
      for (int k = 0; k < SC; k++) begin
        vectors++;
        if (out_valid !== 1'b1 || out_color !== exp_c || ready !== 1'b0) begin
          miscompares++;
          $display("FAIL show[%0d.%0d]: valid=%b color=%0d ready=%b, want valid=1 color=%0d ready=0",
                   i, k, out_valid, out_color, ready, exp_c);
        end
        if (poke_show) begin
          user_valid = 1'b1;
          user_color = exp_c + CW'(1);
        end
        @(negedge clk);
      end
      user_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || ready !== 1'b0) begin
        miscompares++;
        $display("FAIL gap[%0d]: valid=%b ready=%b, want 0 0", i, out_valid, ready);
      end
      @(negedge clk);
    end

    vectors++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_ready: ready=%b valid=%b, want 1 0", ready, out_valid);
    end

    completed = 1'b0;
    for (int i = 0; i < n; i++) begin
      press = (i == wrong_at) ? m_seq[p][i] + CW'(2) : m_seq[p][i];
      user_valid = 1'b1;
      user_color = press;
      @(negedge clk);
      user_valid = 1'b0;
      vectors++;
      if (ready !== 1'b0 || correct !== 1'b0 || fail !== 1'b0) begin
        miscompares++;
        $display("FAIL check_stage[%0d]: ready=%b correct=%b fail=%b, want 0 0 0",
                 i, ready, correct, fail);
      end
      @(negedge clk);
      if (i == wrong_at) begin
        m_len[p] = 0;
        vectors++;
        if (fail !== 1'b1 || correct !== 1'b0 || score_update !== 1'b0) begin
          miscompares++;
          $display("FAIL fail_pulse: fail=%b correct=%b upd=%b, want 1 0 0", fail, correct, score_update);
        end
        vectors++;
        if (seq_len !== '0 || scores !== exp_scores()) begin
          miscompares++;
          $display("FAIL fail_effect: len=%0d scores=%h, want len=0 scores=%h", seq_len, scores, exp_scores());
        end
        break;
      end else if (i == n - 1) begin
        completed  = 1'b1;
        m_score[p] = (m_score[p] + n > (1 << SW) - 1) ? (1 << SW) - 1 : m_score[p] + n;
        vectors++;
        if (correct !== 1'b1 || score_update !== 1'b1 || fail !== 1'b0) begin
          miscompares++;
          $display("FAIL correct_pulse: correct=%b upd=%b fail=%b, want 1 1 0", correct, score_update, fail);
        end
        vectors++;
        if (scores !== exp_scores()) begin
          miscompares++;
          $display("FAIL score: scores=%h, want %h", scores, exp_scores());
        end
      end else begin
        vectors++;
        if (ready !== 1'b1 || correct !== 1'b0 || fail !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_ack[%0d]: ready=%b correct=%b fail=%b, want 1 0 0", i, ready, correct, fail);
        end
      end
    end

    if (completed && n == ML) begin
      vectors++;
      if (game_over !== 1'b1) begin
        miscompares++;
        $display("FAIL game_over_set: game_over=%b, want 1", game_over);
      end
      @(negedge clk);
      vectors++;
      if (correct !== 1'b0 || game_over !== 1'b1 || rnd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL done_hold: correct=%b game_over=%b rnd_ready=%b, want 0 1 0",
                 correct, game_over, rnd_ready);
      end
    end else begin
      @(negedge clk);
      m_cur = (p + 1) % NP;
      vectors++;
      if (correct !== 1'b0 || fail !== 1'b0 || score_update !== 1'b0) begin
        miscompares++;
        $display("FAIL pulse_width: correct=%b fail=%b upd=%b, want 0 0 0", correct, fail, score_update);
      end
      vectors++;
      if (cur_player !== PW'(m_cur) || seq_len !== LW'(m_len[m_cur]) || rnd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL next_player: player=%0d len=%0d rnd_ready=%b, want %0d %0d 1",
                 cur_player, seq_len, rnd_ready, m_cur, m_len[m_cur]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({out_valid, ready, rnd_ready, correct, fail, score_update, game_over,
         out_color, cur_player, seq_len, scores} !== '0) begin
      miscompares++;
      $display("FAIL %s: valid=%b ready=%b rnd_ready=%b correct=%b fail=%b upd=%b over=%b color=%0d player=%0d len=%0d scores=%h, want all 0",
               name, out_valid, ready, rnd_ready, correct, fail, score_update, game_over,
               out_color, cur_player, seq_len, scores);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("power_on_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    model_reset();
  endtask

  task automatic test_single_round();
    new_game();
    play_turn(2'd2, -1, 1'b0);
    vectors++;
    if (scores[SW-1:0] !== SW'(1)) begin
      miscompares++;
      $display("FAIL p0_score: score0=%0d, want 1", scores[SW-1:0]);
    end
  endtask

  task automatic test_reset_mid_show();
    rnd_valid = 1'b1;
    rnd_color = 2'd1;
    @(negedge clk);
    rnd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_show: valid=%b, want 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_show");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_mid_reset");
    model_reset();
  endtask

  task automatic test_handshake();
    new_game();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rnd_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL append_stall[%0d]: rnd_ready=%b valid=%b, want 1 0", i, rnd_ready, out_valid);
      end
      @(negedge clk);
    end
    play_turn(2'd3, -1, 1'b1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (cur_player !== PW'(m_cur) || scores !== exp_scores() || rnd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ignored: player=%0d scores=%h rnd_ready=%b, want %0d %h 1",
               cur_player, scores, rnd_ready, m_cur, exp_scores());
    end

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    rnd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rnd_ready !== 1'b0 || out_valid !== 1'b0 || ready !== 1'b0 || scores !== exp_scores()) begin
        miscompares++;
        $display("FAIL abort_idle[%0d]: rnd_ready=%b valid=%b ready=%b scores=%h, want 0 0 0 %h",
                 i, rnd_ready, out_valid, ready, scores, exp_scores());
      end
      @(negedge clk);
    end
    rnd_valid = 1'b0;

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (rnd_ready !== 1'b0 || scores !== exp_scores()) begin
      miscompares++;
      $display("FAIL start_abort: rnd_ready=%b scores=%h, want 0 %h", rnd_ready, scores, exp_scores());
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_reset();
    vectors++;
    if (rnd_ready !== 1'b1 || scores !== '0 || cur_player !== '0) begin
      miscompares++;
      $display("FAIL restart: rnd_ready=%b scores=%h player=%0d, want 1 0 0", rnd_ready, scores, cur_player);
    end
  endtask

  task automatic test_fail();
    new_game();
    play_turn(2'd1, -1, 1'b0);
    play_turn(2'd0, 0, 1'b0);
    play_turn(2'd2, 0, 1'b0);
    play_turn(2'd3, -1, 1'b0);
    play_turn(2'd1, 0, 1'b0);
    play_turn(2'd1, 0, 1'b0);
    play_turn(2'd0, 2, 1'b0);
  endtask

  task automatic test_saturation_game_over();
    int sched [15];
    sched = '{-1, -1, -1, 0, -1, -1, 0, -1, 1, -1, 1, -1, -1, -1, -1};
    new_game();
    for (int t = 0; t < 15; t++) begin
      play_turn(CW'($urandom_range(0, (1 << CW) - 1)), sched[t], 1'b0);
      if (t < 14) begin
        play_turn(CW'($urandom_range(0, (1 << CW) - 1)), 0, 1'b0);
        play_turn(CW'($urandom_range(0, (1 << CW) - 1)), 0, 1'b0);
      end
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (game_over !== 1'b1 || scores[SW-1:0] !== SW'((1 << SW) - 1)) begin
      miscompares++;
      $display("FAIL sat_hold: game_over=%b score0=%0d, want 1 %0d", game_over, scores[SW-1:0], (1 << SW) - 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (game_over !== 1'b1 || scores !== exp_scores()) begin
      miscompares++;
      $display("FAIL abort_keeps: game_over=%b scores=%h, want 1 %h", game_over, scores, exp_scores());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_reset();
    vectors++;
    if (game_over !== 1'b0 || scores !== '0 || rnd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL new_game_clear: game_over=%b scores=%h rnd_ready=%b, want 0 0 1", game_over, scores, rnd_ready);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_round();
    test_reset_mid_show();
    test_handshake();
    test_fail();
    test_saturation_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
- Parametrised Simon/Genius round engine: the next generation of the game control path, generalised to N players, configurable colour width, sequence depth and scoring.
- Stores one colour sequence per player and appends a colour each round from an external random source.
- Plays the sequence back with timed display, checks the player's input element by element, and updates saturating scores.
- Sits between the random colour generator and input debouncer on one side, and the display and score display on the other.

Parameters:
- NUM_PLAYERS, 2, number of players taking alternating turns (1..8).
- COLOR_W, 2, bits per colour code (4 colours at default).
- MAX_LEN, 32, maximum sequence length per player (power of two, >=2).
- SCORE_W, 8, width of each player's score.
- SHOW_CYCLES, 4, clock cycles each colour is held on out_color (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: clear scores and sequences, begin with player 0
- abort  input  1  pulse: return to IDLE, scores kept
- rnd_valid  input  1  random colour available
- rnd_color  input  COLOR_W  random colour to append
- rnd_ready  output  1  engine consumes rnd_color this cycle when rnd_valid=1
- out_valid  output  1  out_color is being displayed
- out_color  output  COLOR_W  colour under display
- ready  output  1  engine accepts user input
- user_valid  input  1  user pressed a colour
- user_color  input  COLOR_W  colour pressed
- correct  output  1  pulse: round completed with full match
- fail  output  1  pulse: mismatch detected
- cur_player  output  clog2(NUM_PLAYERS) (min 1)  player whose turn it is
- seq_len  output  clog2(MAX_LEN)+1  current player's sequence length
- scores  output  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
- score_update  output  1  pulse: scores changed this cycle
- game_over  output  1  level: a player completed a MAX_LEN sequence

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0; scores, sequence lengths and cur_player cleared. Storage contents are don't-care.
- States: IDLE, APPEND, SHOW, GAP, WAIT_IN, CHECK, NEXT, DONE.
- IDLE: start -> all lengths=0, scores=0, cur_player=0 -> APPEND. All other inputs ignored.
- APPEND: rnd_ready=1. On a cycle with rnd_valid&rnd_ready, rnd_color is written at index len[cur_player] and len is incremented. Next state SHOW with idx=0.
- SHOW: out_valid=1, out_color=seq[cur][idx] for exactly SHOW_CYCLES cycles, then GAP.
- GAP: 1 cycle with out_valid=0. Then idx+1 -> SHOW if idx+1<len, else idx=0 -> WAIT_IN.
- WAIT_IN: ready=1. user_valid is accepted only when ready=1; otherwise it is ignored. On acceptance the colour is registered and the state moves to CHECK; ready=0 in CHECK.
- CHECK (1 cycle, i.e. response one cycle after acceptance):
  - Mismatch: fail=1, len[cur]=0, -> NEXT.
  - Match with idx<len-1: idx+1 -> WAIT_IN, no pulse.
  - Match with idx=len-1: correct=1, score_update=1, score[cur] += len, saturating at 2^SCORE_W-1. Then -> DONE if len==MAX_LEN, else -> NEXT.
- NEXT: cur_player = (cur_player+1) mod NUM_PLAYERS -> APPEND. seq_len always reflects cur_player.
- DONE: game_over=1 and held. Only start (new game) or abort leaves DONE.
- abort: in any state, takes effect next edge -> IDLE. Scores and game_over are kept until the next start; out_valid, ready and rnd_ready drop at once.
- Simultaneous start and abort: abort wins.
- start outside IDLE/DONE is ignored.
- rnd_valid low in APPEND: the engine waits indefinitely.
- A failed player restarts from length 0 on their next turn; their score is retained.
- Pulses (correct, fail, score_update) are exactly 1 cycle.

Test Plan:
- Reset mid-SHOW (rst_n low 1 cycle): all outputs 0 immediately without a clock edge; FSM IDLE; scores 0.
- start, rnd_color=2, user presses 2 (SHOW_CYCLES=4):
  - out_valid high 4 cycles with out_color=2, then 1 gap cycle, then ready=1.
  - Cycle after press: correct=1, score_update=1, scores[7:0]=1, cur_player->1.
- P0 at len 3 with sequence {1,3,0}, user enters 1,3,2 -> fail pulse one cycle after the third press; P0 seq_len=0; score unchanged; cur_player=1.
- Saturation: SCORE_W=4 and score[0]=14; a round completing at len=3 -> score[0]=15, not 1.
- MAX_LEN=4, P0 completes the fourth colour correctly -> correct pulse, then game_over=1 held; start clears game_over and scores.
- Handshake and edge inputs:
  - rnd_valid held low 10 cycles in APPEND -> rnd_ready stays 1 and no SHOW occurs.
  - user_valid during SHOW is ignored.
  - start+abort in the same cycle -> IDLE.
